// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bundle: hazard-unit controls, EX redirect, imem port, IF/ID outputs and perf counters.
// The environment (hazard unit, EX, imem, decode) takes master; the fetch stage takes slave.
interface if_fetch_stage_if #(
  parameter int CNT_W = 32
);
  logic             pc_en;
  logic             if_id_pipeline_en;
  logic             if_id_pipeline_flush;
  logic             jump_branch_taken;
  logic [31:0]      jump_branch_target;
  logic [31:0]      imem_addr;
  logic             imem_rd_en;
  logic [31:0]      imem_rdata;
  logic [31:0]      if_pc;
  logic [31:0]      if_instr;
  logic             if_valid;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] redirect_cnt;

  modport master (
    output pc_en, if_id_pipeline_en, if_id_pipeline_flush,
    output jump_branch_taken, jump_branch_target, imem_rdata,
    input  imem_addr, imem_rd_en, if_pc, if_instr, if_valid,
    input  stall_cnt, redirect_cnt
  );

  modport slave (
    input  pc_en, if_id_pipeline_en, if_id_pipeline_flush,
    input  jump_branch_taken, jump_branch_target, imem_rdata,
    output imem_addr, imem_rd_en, if_pc, if_instr, if_valid,
    output stall_cnt, redirect_cnt
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch front end with IF/ID register: drives a 1-cycle synchronous imem,
// replays the returned word across load stalls, and redirects to EX-resolved targets.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 32
) (
  input  logic           clk,
  input  logic           rst,
  if_fetch_stage_if.slave bus
);

  logic [31:0]      pc_q;
  logic [31:0]      f1_pc;
  logic             f1_valid;
  logic [31:0]      hold_instr;
  logic             hold_valid;
  logic [31:0]      if_pc_q;
  logic [31:0]      if_instr_q;
  logic             if_valid_q;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] redirect_q;
  logic [31:0]      f1_word;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Once a stall has begun, imem returns the word for the stalled pc_q, so the
  // word that belonged to f1_pc must come from the replay buffer instead.
  assign f1_word = hold_valid ? hold_instr : bus.imem_rdata;

  // PC, in-flight fetch slot and replay buffer; redirect outranks a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      f1_pc      <= 32'h0000_0000;
      f1_valid   <= 1'b0;
      hold_instr <= 32'h0000_0000;
      hold_valid <= 1'b0;
    end else if (bus.jump_branch_taken) begin
      pc_q       <= {bus.jump_branch_target[31:2], 2'b00};
      f1_valid   <= 1'b0;
      hold_valid <= 1'b0;
    end else if (bus.pc_en) begin
      pc_q       <= pc_q + 32'd4;
      f1_pc      <= pc_q;
      f1_valid   <= 1'b1;
      hold_valid <= 1'b0;
    end else if (!hold_valid) begin
      hold_instr <= bus.imem_rdata;
      hold_valid <= 1'b1;
    end else begin
      hold_valid <= 1'b1;
    end
  end

  // IF/ID register: flush, capture, or bubble when decode advances without a new fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_pc_q    <= 32'h0000_0000;
      if_instr_q <= NOP_INSTR;
      if_valid_q <= 1'b0;
    end else if (bus.if_id_pipeline_flush) begin
      if_instr_q <= NOP_INSTR;
      if_valid_q <= 1'b0;
    end else if (bus.if_id_pipeline_en && bus.pc_en) begin
      if_pc_q    <= f1_pc;
      if_instr_q <= f1_word;
      if_valid_q <= f1_valid;
    end else if (bus.if_id_pipeline_en) begin
      if_instr_q <= NOP_INSTR;
      if_valid_q <= 1'b0;
    end else begin
      if_valid_q <= if_valid_q;
    end
  end

  // Saturating performance counters; a redirect cycle is never counted as a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q    <= '0;
      redirect_q <= '0;
    end else if (bus.jump_branch_taken) begin
      redirect_q <= sat_inc(redirect_q);
    end else if (!bus.pc_en) begin
      stall_q    <= sat_inc(stall_q);
    end else begin
      stall_q    <= stall_q;
    end
  end

  assign bus.imem_addr    = pc_q;
  assign bus.imem_rd_en   = ~rst;
  assign bus.if_pc        = if_pc_q;
  assign bus.if_instr     = if_instr_q;
  assign bus.if_valid     = if_valid_q;
  assign bus.stall_cnt    = stall_q;
  assign bus.redirect_cnt = redirect_q;

endmodule
